// File: rtl/pipe_adder.sv
// Pipelined ripple adder/subtractor: the carry chain is cut into STAGES segments of
// SIZE/STAGES bits, with skew registers carrying the unprocessed operand bits forward.
module pipe_adder #(
  parameter int SIZE   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] X,
  input  logic [SIZE-1:0] Y,
  input  logic            CIN,
  input  logic            SUB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] S,
  output logic            COUT,
  output logic            OVF
);
  localparam int STG   = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = SIZE / STG;

  if (STAGES < 1 || SIZE < 1 || (SIZE % STG) != 0) begin : g_param_chk
    $error("pipe_adder: SIZE must be a positive exact multiple of STAGES, STAGES >= 1");
  end

  logic            w_en;
  logic [SIZE-1:0] w_yi;
  logic            w_cin;

  // Subtract is X + ~Y + ~CIN, so the carry-in doubles as an inverted borrow-in.
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;
  assign w_yi     = SUB ? ~Y : Y;
  assign w_cin    = CIN ^ SUB;

  for (genvar k = 0; k < STG; k++) begin : g_stg
    localparam int LO  = k * CHUNK;
    localparam int REM = SIZE - LO;

    logic [REM-1:0]      w_a;
    logic [REM-1:0]      w_b;
    logic                w_ci;
    logic                w_vin;
    logic [CHUNK:0]      w_sum;
    logic [LO+CHUNK-1:0] w_s_nxt;
    logic                r_vld;
    logic                r_c;
    logic [LO+CHUNK-1:0] r_s;

    // ---- stage k input: operands straight from the ports, or from stage k-1 skew regs
    if (k == 0) begin : g_head
      assign w_a     = X;
      assign w_b     = w_yi;
      assign w_ci    = w_cin;
      assign w_vin   = in_valid & in_ready;
      assign w_s_nxt = w_sum[CHUNK-1:0];
    end else begin : g_body
      assign w_a     = g_stg[k-1].g_fwd.r_x;
      assign w_b     = g_stg[k-1].g_fwd.r_y;
      assign w_ci    = g_stg[k-1].r_c;
      assign w_vin   = g_stg[k-1].r_vld;
      assign w_s_nxt = {w_sum[CHUNK-1:0], g_stg[k-1].r_s};
    end

    assign w_sum = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_ci};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
      end else if (w_en) begin
        r_vld <= w_vin;
      end
    end

    always_ff @(posedge clk) begin
      if (w_en) begin
        r_c <= w_sum[CHUNK];
        r_s <= w_s_nxt;
      end
    end

    // ---- stage k output: skew regs for upper bits, or overflow flag on the last stage
    if (k < STG - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] r_x;
      logic [REM-CHUNK-1:0] r_y;

      always_ff @(posedge clk) begin
        if (w_en) begin
          r_x <= w_a[REM-1:CHUNK];
          r_y <= w_b[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_ovf <= (w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_sum[CHUNK-1]) ^ w_sum[CHUNK];
        end
      end
    end
  end

  // Result outputs read as zero whenever no valid result is held, including in reset.
  assign out_valid = g_stg[STG-1].r_vld;
  assign S         = out_valid ? g_stg[STG-1].r_s : '0;
  assign COUT      = out_valid & g_stg[STG-1].r_c;
  assign OVF       = out_valid & g_stg[STG-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (SIZE=32, STAGES=4).
module tb_pipe_adder;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic        CIN;
  logic        SUB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        COUT;
  logic        OVF;

  int n_cmp = 0;
  int n_err = 0;

  pipe_adder #(.SIZE(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .CIN       (CIN),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .COUT      (COUT),
    .OVF       (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: checks latency and the result word.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic cin, input logic sub, input logic [31:0] es,
                        input logic ec, input logic eo);
    X = x; Y = y; CIN = cin; SUB = sub; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; X = $urandom; Y = $urandom; CIN = 1'b0; SUB = 1'b0;
    tick();
    tick();
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
    chk({tag, "_s"},    S, es);
    chk({tag, "_cout"}, {31'd0, COUT}, {31'd0, ec});
    chk({tag, "_ovf"},  {31'd0, OVF},  {31'd0, eo});
  endtask

  logic [31:0] sx [8];
  logic [31:0] sy [8];
  logic        sc [8];
  logic        ss [8];
  logic [31:0] es [8];
  logic        ec [8];
  logic        eo [8];

  initial begin
    int idx;
    int oidx;
    logic acc;
    logic deq;

    // stream table: X, Y, CIN, SUB -> S, COUT, OVF
    sx[0] = 32'h00000001; sy[0] = 32'h00000002; sc[0] = 0; ss[0] = 0; es[0] = 32'h00000003; ec[0] = 0; eo[0] = 0;
    sx[1] = 32'hFFFFFFFF; sy[1] = 32'h00000001; sc[1] = 0; ss[1] = 0; es[1] = 32'h00000000; ec[1] = 1; eo[1] = 0;
    sx[2] = 32'h0000000A; sy[2] = 32'h00000003; sc[2] = 0; ss[2] = 1; es[2] = 32'h00000007; ec[2] = 1; eo[2] = 0;
    sx[3] = 32'h7FFFFFFF; sy[3] = 32'h7FFFFFFF; sc[3] = 1; ss[3] = 0; es[3] = 32'hFFFFFFFF; ec[3] = 0; eo[3] = 1;
    sx[4] = 32'h0000FFFF; sy[4] = 32'h00000001; sc[4] = 0; ss[4] = 0; es[4] = 32'h00010000; ec[4] = 0; eo[4] = 0;
    sx[5] = 32'h00000003; sy[5] = 32'h00000005; sc[5] = 0; ss[5] = 1; es[5] = 32'hFFFFFFFE; ec[5] = 0; eo[5] = 0;
    sx[6] = 32'h12345678; sy[6] = 32'h87654321; sc[6] = 0; ss[6] = 0; es[6] = 32'h99999999; ec[6] = 0; eo[6] = 0;
    sx[7] = 32'h80000000; sy[7] = 32'h00000001; sc[7] = 1; ss[7] = 1; es[7] = 32'h7FFFFFFE; ec[7] = 1; eo[7] = 1;

    // reset with random inputs
    rst_n = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); X = $urandom; Y = $urandom; CIN = 1'($urandom); SUB = 1'($urandom);
      tick();
    end
    chk("rst_vld",   {31'd0, out_valid}, 32'd0);
    chk("rst_s",     S, 32'd0);
    chk("rst_cout",  {31'd0, COUT}, 32'd0);
    chk("rst_ovf",   {31'd0, OVF}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // directed single operations
    run_op("ripple",  32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0);
    run_op("addovf",  32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1);
    run_op("subovf",  32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1);
    run_op("subneg",  32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 0, 0);
    run_op("subbin",  32'h00000005, 32'h00000003, 1, 1, 32'h00000001, 1, 0);
    run_op("addcin",  32'h12345678, 32'h11111111, 1, 0, 32'h2345678A, 0, 0);
    run_op("negovf",  32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1);
    run_op("chunks",  32'h00FF00FF, 32'h00010001, 0, 0, 32'h01000100, 0, 0);
    tick();
    tick();

    // back-to-back stream with out_ready low on cycles 5..7
    idx = 0; oidx = 0;
    for (int n = 0; n < 40 && oidx < 8; n++) begin
      out_ready = !(n >= 5 && n <= 7);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        X = sx[idx]; Y = sy[idx]; CIN = sc[idx]; SUB = ss[idx];
      end
      #1;
      acc = in_valid & in_ready;
      deq = out_valid & out_ready;
      if (n >= 5 && n <= 7) begin
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_vld",   {31'd0, out_valid}, 32'd1);
        chk("stall_s",     S, es[oidx]);
      end
      if (deq) begin
        chk($sformatf("strm%0d_s", oidx),    S, es[oidx]);
        chk($sformatf("strm%0d_cout", oidx), {31'd0, COUT}, {31'd0, ec[oidx]});
        chk($sformatf("strm%0d_ovf", oidx),  {31'd0, OVF},  {31'd0, eo[oidx]});
        oidx++;
      end
      if (acc) idx++;
      tick();
    end
    chk("strm_count", oidx, 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    // reset in flight: op0 reaches the output, then an async reset discards everything
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; X = sx[i]; Y = sy[i]; CIN = sc[i]; SUB = ss[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mid_vld_pre", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_vld_async", {31'd0, out_valid}, 32'd0);
    chk("mid_s_async",   S, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mid_quiet%0d", i), {31'd0, out_valid}, 32'd0);
    end

    run_op("post_rst", 32'h00000064, 32'h00000001, 0, 0, 32'h00000065, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
